// File: rtl/mem_access_tracer.sv
// mem_access_tracer: snoops a data bus and records matching accesses into a
// circular trace buffer. Each entry holds the access direction, the address,
// the data and a 16-bit timestamp. The oldest entry is presented on a
// first-word-fall-through readout port.
// Optional feature macro: TRACE_READS_EN (reads are also traced when defined).
// WRAP=0 stops capturing once the buffer is full. WRAP=1 overwrites the oldest entry.
module mem_access_tracer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int WRAP   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm_i,
    input  logic                     data_ce_i,
    input  logic                     data_we_i,
    input  logic [ADDR_W-1:0]        data_addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [DATA_W-1:0]        rdata_i,
    input  logic [ADDR_W-1:0]        filt_lo_i,
    input  logic [ADDR_W-1:0]        filt_hi_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic                     rd_we_o,
    output logic [ADDR_W-1:0]        rd_addr_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [15:0]              rd_stamp_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic [15:0]              drop_cnt_o,
    output logic [1:0]               state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic             WRAP_EN  = (WRAP != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_HALT    = 2'b10
    } state_t;

    // Trace storage. The contents are not reset because only the pointers
    // decide which entries are valid.
    logic              r_mem_we    [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
    logic [DATA_W-1:0] r_mem_data  [DEPTH];
    logic [15:0]       r_mem_stamp [DEPTH];

    state_t            r_state;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_valid;
    logic [15:0]       r_stamp;
    logic [15:0]       r_drop;
    logic              r_rd_we;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_rd_data;
    logic [15:0]       r_rd_stamp;

    logic              w_in_win;
    logic              w_kind_ok;
    logic              w_event;
    logic              w_cap;
    logic              w_full;
    logic              w_pop;
    logic              w_drop;
    logic              w_wr;
    logic              w_adv;
    logic [DATA_W-1:0] w_e_data;
    logic [PTR_W-1:0]  w_wptr_nxt;
    logic [PTR_W-1:0]  w_rptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_bypass;
    logic              w_head_we;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [15:0]       w_head_stamp;

    // Event qualification, push/pop/drop decisions and next pointer/count values.
    always_comb begin
        w_in_win = (filt_lo_i <= data_addr_i) && (data_addr_i <= filt_hi_i);
`ifdef TRACE_READS_EN
        w_kind_ok = 1'b1;
`else
        w_kind_ok = data_we_i;
`endif
        w_event  = data_ce_i && w_in_win && w_kind_ok;
        w_cap    = (r_state == ST_CAPTURE) && w_event;
        w_full   = (r_count == FULL_CNT);
        w_pop    = (r_count != CNT_ZERO) && rd_ready_i;
        w_drop   = w_cap && w_full && !w_pop;
        // When the buffer is full, a write needs a concurrent pop or WRAP mode.
        w_wr     = w_cap && (!w_full || w_pop || WRAP_EN);
        // The read pointer moves on a pop, or when WRAP overwrites the oldest entry.
        w_adv    = w_pop || (w_drop && WRAP_EN);
        w_e_data = data_we_i ? wdata_i : rdata_i;

        if (w_wr) begin
            w_wptr_nxt = r_wptr + PTR_ONE;
        end else begin
            w_wptr_nxt = r_wptr;
        end

        if (w_adv) begin
            w_rptr_nxt = r_rptr + PTR_ONE;
        end else begin
            w_rptr_nxt = r_rptr;
        end

        if (w_wr && !w_adv) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_adv && !w_wr) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end

        // A write into the slot that becomes the head must be forwarded.
        // The storage still holds the old value of that slot in this cycle.
        w_bypass = w_wr && (r_wptr == w_rptr_nxt);
        if (w_bypass) begin
            w_head_we    = data_we_i;
            w_head_addr  = data_addr_i;
            w_head_data  = w_e_data;
            w_head_stamp = r_stamp;
        end else begin
            w_head_we    = r_mem_we[w_rptr_nxt];
            w_head_addr  = r_mem_addr[w_rptr_nxt];
            w_head_data  = r_mem_data[w_rptr_nxt];
            w_head_stamp = r_mem_stamp[w_rptr_nxt];
        end
    end

    // Write the captured entry into the tail slot.
    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            r_mem_we[r_wptr]    <= data_we_i;
            r_mem_addr[r_wptr]  <= data_addr_i;
            r_mem_data[r_wptr]  <= w_e_data;
            r_mem_stamp[r_wptr] <= r_stamp;
        end
    end

    // Free-running 16-bit timestamp. It wraps naturally from 0xFFFF to 0x0000.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stamp <= 16'h0000;
        end else begin
            r_stamp <= r_stamp + 16'h0001;
        end
    end

    // Count of lost or overwritten events. It saturates at 0xFFFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 16'h0000;
        end else if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'h0001;
        end else begin
            r_drop <= r_drop;
        end
    end

    // Update the buffer pointers and the occupancy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_count <= CNT_ZERO;
            r_full  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_valid <= (w_count_nxt != CNT_ZERO);
        end
    end

    // Register the fields of the next head entry for the readout port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_we    <= 1'b0;
            r_rd_addr  <= {ADDR_W{1'b0}};
            r_rd_data  <= {DATA_W{1'b0}};
            r_rd_stamp <= 16'h0000;
        end else begin
            r_rd_we    <= w_head_we;
            r_rd_addr  <= w_head_addr;
            r_rd_data  <= w_head_data;
            r_rd_stamp <= w_head_stamp;
        end
    end

    // Capture control FSM. Disarming takes priority over halting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm_i) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (!arm_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_drop && !WRAP_EN) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_HALT: begin
                    if (!arm_i && (r_count == CNT_ZERO)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_HALT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_valid_o = r_valid;
    assign rd_we_o    = r_rd_we;
    assign rd_addr_o  = r_rd_addr;
    assign rd_data_o  = r_rd_data;
    assign rd_stamp_o = r_rd_stamp;
    assign count_o    = r_count;
    assign full_o     = r_full;
    assign drop_cnt_o = r_drop;
    assign state_o    = r_state;

endmodule

// File: doc/mem_access_tracer.md
MEM_ACCESS_TRACER -- requirements
Module: mem_access_tracer

Interface
REQ-001 Parameter ADDR_W, default 32, data-bus address width.
REQ-002 Parameter DATA_W, default 32, data-bus data width.
REQ-003 Parameter DEPTH, default 16, trace entries; power of two, >= 2.
REQ-004 Parameter WRAP, default 0; 0 halts capture when full, 1 overwrites the oldest entry.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 arm_i  in  1  1 = request capture, 0 = disarm.
REQ-008 data_ce_i, data_we_i  in  1 each  data-bus chip enable and write enable, snooped.
REQ-009 data_addr_i  in  ADDR_W  data-bus address.
REQ-010 wdata_i, rdata_i  in  DATA_W each  write data and read data (same-cycle memory).
REQ-011 filt_lo_i, filt_hi_i  in  ADDR_W each  inclusive capture address window.
REQ-012 rd_valid_o  out  1, rd_ready_i  in  1  readout handshake.
REQ-013 rd_we_o  out  1, rd_addr_o  out  ADDR_W, rd_data_o  out  DATA_W, rd_stamp_o  out  16  head entry fields.
REQ-014 count_o  out  $clog2(DEPTH)+1  occupied entries; full_o  out  1  count_o == DEPTH.
REQ-015 drop_cnt_o  out  16  lost or overwritten events; state_o  out  2  FSM state.

Function
REQ-016 A 16-bit timestamp counter increments every cycle and wraps 0xFFFF -> 0x0000.
REQ-017 Event = data_ce_i & (filt_lo_i <= data_addr_i <= filt_hi_i, unsigned) & (data_we_i | reads enabled per REQ-033).
REQ-018 Entry = {data_we_i, data_addr_i, data_we_i ? wdata_i : rdata_i, timestamp of that cycle}.
REQ-019 States: IDLE=2'b00, CAPTURE=2'b01, HALT=2'b10; 2'b11 is unreachable.
REQ-020 IDLE -> CAPTURE on arm_i=1; CAPTURE -> IDLE on arm_i=0; HALT -> IDLE only when arm_i=0 and count_o=0.
REQ-021 Events are pushed only in CAPTURE, on the rising edge where the event is present; no latency beyond that edge.
REQ-022 rd_valid_o = (count_o != 0); first-word-fall-through; head entry popped on edge with rd_valid_o & rd_ready_i; readout works in every state.
REQ-023 Push and pop in same cycle: both take effect, count_o unchanged, including when full.
REQ-024 WRAP=0, full, event, no pop: entry discarded, drop_cnt_o +1, state -> HALT.
REQ-025 WRAP=1, full, event, no pop: oldest entry overwritten (read pointer advances), drop_cnt_o +1, state stays CAPTURE.
REQ-026 drop_cnt_o saturates at 0xFFFF.
REQ-027 Pop on empty is ignored; pointers wrap modulo DEPTH.
REQ-028 Filter with filt_lo_i > filt_hi_i matches nothing.
REQ-029 rd_* fields are don't-care while rd_valid_o = 0.

Reset
REQ-030 On rst=1 at a rising edge: state IDLE, count_o 0, pointers 0, full_o 0, rd_valid_o 0, drop_cnt_o 0, timestamp 0.
REQ-031 rst overrides any concurrent push, pop or transition; buffer contents need not be cleared; rd_we_o/rd_addr_o/rd_data_o/rd_stamp_o reset to 0.
REQ-032 Reset mid-capture discards all entries; capture resumes only after a fresh arm_i=1 in IDLE.

Configuration
REQ-033 Macro TRACE_READS_EN: when defined, reads (data_we_i=0) qualify as events with data from rdata_i; when undefined, only writes qualify and rd_we_o reads as 1 for every entry.

Verification
REQ-034 Reset, arm, write 0x00000010 <- 0x12345678 in window [0x0,0xFF] -> one entry {1,0x10,0x12345678,stamp}, count_o=1, rd_valid_o=1.
REQ-035 WRAP=0, DEPTH=4, rd_ready_i=0, 5 writes -> count_o=4, full_o=1, drop_cnt_o=1, state_o=HALT; drain 4, arm_i=0 -> IDLE.
REQ-036 WRAP=1, DEPTH=4, writes data 1..6 -> readout yields 3,4,5,6; drop_cnt_o=2; state stays CAPTURE.
REQ-037 Full buffer, write event with rd_ready_i=1 same cycle -> count_o stays 4, drop_cnt_o unchanged, new entry at tail.
REQ-038 Write to 0x200 with window [0x0,0xFF] -> no entry; read of 0x20 returning 0xCAFE -> entry {0,0x20,0xCAFE} with TRACE_READS_EN, none without.
REQ-039 rst asserted with 3 entries buffered in CAPTURE -> next cycle count_o=0, rd_valid_o=0, state_o=IDLE, drop_cnt_o=0.
